// File: rtl/prog_load_arb.sv
// UART program loader sharing one memory port with the CPU. In RUN the CPU
// owns the port. In the programming states the CPU is stalled and received
// bytes are packed little-endian into 32-bit words and written sequentially
// from address 0. A load ends on start_pg low, an idle timeout, or when the
// memory is full.
module prog_load_arb #(
  parameter int ADDR_W  = 14,
  parameter int IDLE_TO = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              cpu_mem_req,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [31:0]       cpu_mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              prog_busy,
  output logic              program_off,
  output logic              uart_write_en,
  output logic [ADDR_W:0]   word_count,
  output logic              prog_overflow
);

  localparam int IDLE_W = $clog2(IDLE_TO) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TO - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = {{(IDLE_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WORD_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {RUN, PG_WAIT, PG_RX, PG_WR, PG_DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [1:0]        byte_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic [31:0]       word_buf;
  logic [31:0]       wr_word;
  logic              final_wr;
  logic              end_load;
  logic              wr_last;
  logic              wr_take;

  // The load ends when no byte arrives and either start_pg has dropped or the
  // idle counter is about to reach IDLE_TO-1.
  assign end_load  = !rx_valid && (!start_pg || ((idle_cnt + IDLE_ONE) == IDLE_LAST));
  // The write in progress fills the last memory word.
  assign wr_last   = (word_count == WORD_LAST);
  // A byte arriving during a write starts the next word unless the load is over.
  assign wr_take   = rx_valid && !wr_last && !final_wr;
  assign prog_busy = (state != RUN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

  // Next-state decode and shared memory port mux.
  always_comb begin
    next_state    = state;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cpu_stall     = 1'b1;
    uart_write_en = 1'b0;
    case (state)
      RUN: begin
        mem_en    = cpu_mem_req;
        mem_we    = cpu_mem_req & cpu_mem_we;
        mem_addr  = cpu_mem_addr;
        mem_wdata = cpu_mem_wdata;
        cpu_stall = 1'b0;
        if (start_pg) next_state = PG_WAIT;
      end
      PG_WAIT: begin
        if (!start_pg)     next_state = PG_DONE;
        else if (rx_valid) next_state = PG_RX;
      end
      PG_RX: begin
        if (rx_valid) begin
          if (byte_idx == 2'd3) next_state = PG_WR;
        end else if (end_load) begin
          next_state = (byte_idx != 2'd0) ? PG_WR : PG_DONE;
        end
      end
      PG_WR: begin
        mem_en        = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = word_count[ADDR_W-1:0];
        mem_wdata     = wr_word;
        uart_write_en = 1'b1;
        next_state    = (wr_last || final_wr) ? PG_DONE : PG_RX;
      end
      PG_DONE: next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // Loader datapath: byte assembly, idle timer, word counter and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count    <= '0;
      byte_idx      <= '0;
      idle_cnt      <= '0;
      word_buf      <= '0;
      wr_word       <= '0;
      final_wr      <= 1'b0;
      program_off   <= 1'b0;
      prog_overflow <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (start_pg) begin
            word_count    <= '0;
            byte_idx      <= '0;
            idle_cnt      <= '0;
            word_buf      <= '0;
            final_wr      <= 1'b0;
            program_off   <= 1'b0;
            prog_overflow <= 1'b0;
          end
        end
        PG_WAIT: begin
          if (start_pg && rx_valid) begin
            word_buf[7:0] <= rx_data;
            byte_idx      <= 2'd1;
            idle_cnt      <= '0;
          end
        end
        PG_RX: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_word  <= {rx_data, word_buf[23:0]};
              word_buf <= '0;
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end else if (end_load) begin
            if (byte_idx != 2'd0) begin
              wr_word  <= word_buf;
              word_buf <= '0;
              byte_idx <= '0;
              final_wr <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt + IDLE_ONE;
          end
        end
        PG_WR: begin
          word_count <= word_count + WORD_ONE;
          if (wr_last) prog_overflow <= 1'b1;
          if (wr_take) begin
            word_buf[7:0] <= rx_data;
            byte_idx      <= 2'd1;
            idle_cnt      <= '0;
          end
        end
        PG_DONE: begin
          program_off <= 1'b1;
          final_wr    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_arb.sv
// Scoreboard bench for prog_load_arb: a default-size instance (a) and a
// small instance (b, ADDR_W=2, IDLE_TO=16). Expected writes come from a
// byte-list model and are popped by a monitor on every loader write strobe.
module tb_prog_load_arb;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wdata;

  logic        en_a, we_a, stall_a, busy_a, off_a, uwe_a, ovf_a;
  logic [13:0] addr_a;
  logic [31:0] wdata_a;
  logic [14:0] wc_a;
  logic        en_b, we_b, stall_b, busy_b, off_b, uwe_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  wc_b;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  exp_t       ea, eb;
  logic [7:0] stim[$];
  int tests = 0, fails = 0, cyc = 0, last_cyc = 0, wr_cnt_a = 0, wr_cnt_b = 0;

  prog_load_arb u_dut_a (
    .clk(clk), .rst(rst), .start_pg(start_a), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_mem_req(cpu_req), .cpu_mem_we(cpu_we), .cpu_mem_addr(cpu_addr), .cpu_mem_wdata(cpu_wdata),
    .mem_en(en_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .cpu_stall(stall_a), .prog_busy(busy_a), .program_off(off_a), .uart_write_en(uwe_a),
    .word_count(wc_a), .prog_overflow(ovf_a)
  );

  prog_load_arb #(.ADDR_W(2), .IDLE_TO(16)) u_dut_b (
    .clk(clk), .rst(rst), .start_pg(start_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_mem_req(cpu_req), .cpu_mem_we(cpu_we), .cpu_mem_addr(cpu_addr[1:0]), .cpu_mem_wdata(cpu_wdata),
    .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .cpu_stall(stall_b), .prog_busy(busy_b), .program_off(off_b), .uart_write_en(uwe_b),
    .word_count(wc_b), .prog_overflow(ovf_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used to time writes against the last received byte.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic reportMissing(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got a write strobe, required none (no expected write queued)", name);
  endtask

  // Monitor: every loader write is matched against the scoreboard; any other
  // busy cycle must leave the memory port idle.
  always @(negedge clk) begin
    if (rst) begin
      if (uwe_a) begin
        wr_cnt_a++;
        if (exp_a.size() == 0) reportMissing("a_unexpected_write");
        else begin
          ea = exp_a.pop_front();
          checkOutput("a_wr_addr", 32'(addr_a), 32'(ea.addr));
          checkOutput("a_wr_data", wdata_a, ea.data);
          checkOutput("a_wr_en_we", {30'd0, en_a, we_a}, 32'd3);
          if (ea.cyc >= 0) checkOutput("a_wr_cycle", cyc, ea.cyc);
        end
      end else if (busy_a) begin
        checkOutput("a_busy_port_idle", {30'd0, en_a, we_a}, 32'd0);
      end
      if (uwe_b) begin
        wr_cnt_b++;
        if (exp_b.size() == 0) reportMissing("b_unexpected_write");
        else begin
          eb = exp_b.pop_front();
          checkOutput("b_wr_addr", 32'(addr_b), 32'(eb.addr));
          checkOutput("b_wr_data", wdata_b, eb.data);
          checkOutput("b_wr_en_we", {30'd0, en_b, we_b}, 32'd3);
          if (eb.cyc >= 0) checkOutput("b_wr_cycle", cyc, eb.cyc);
        end
      end else if (busy_b) begin
        checkOutput("b_busy_port_idle", {30'd0, en_b, we_b}, 32'd0);
      end
    end
  end

  // Random CPU traffic, which must be ignored while loading.
  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    forever begin
      @(posedge clk); #2;
      cpu_req   = 1'($urandom);
      cpu_we    = 1'($urandom);
      cpu_addr  = 14'($urandom);
      cpu_wdata = $urandom;
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic setStart(input int which, input logic v);
    if (which == 1) start_b = v;
    else            start_a = v;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic fillRandom(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  task automatic checkPassthrough();
    @(negedge clk);
    checkOutput("a_pass_en", 32'(en_a), 32'(cpu_req));
    checkOutput("a_pass_we", 32'(we_a), 32'(cpu_req & cpu_we));
    checkOutput("a_pass_addr", 32'(addr_a), 32'(cpu_addr));
    checkOutput("a_pass_wdata", wdata_a, cpu_wdata);
    checkOutput("a_stall_run", 32'(stall_a), 32'd0);
    checkOutput("b_pass_addr", 32'(addr_b), 32'(cpu_addr[1:0]));
    checkOutput("b_pass_we", 32'(we_b), 32'(cpu_req & cpu_we));
    @(posedge clk); #1;
  endtask

  // Runs one load of the bytes in stim on instance 'which'. Bytes from index
  // dropAt onward are sent after start_pg falls and must all be discarded.
  task automatic applyStimulus(input int which, input int gapMax, input int dropAt, input string tag);
    int acc, cap, nw, nwc, w0;
    logic [31:0] d;
    exp_t e;
    acc = (dropAt >= 0 && dropAt < stim.size()) ? dropAt : stim.size();
    cap = (which == 1) ? 4 : 16384;
    nw  = (acc + 3) / 4;
    nwc = (nw > cap) ? cap : nw;
    for (int w = 0; w < nwc; w++) begin
      d = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < acc) d[8 * k +: 8] = stim[4 * w + k];
      e.addr = w; e.data = d; e.cyc = -1;
      if (which == 1) exp_b.push_back(e);
      else            exp_a.push_back(e);
    end
    w0 = (which == 1) ? wr_cnt_b : wr_cnt_a;
    setStart(which, 1'b1);
    step(2);
    foreach (stim[i]) begin
      if (i == dropAt) setStart(which, 1'b0);
      sendByte(stim[i]);
      if (gapMax > 0) step(int'($urandom_range(gapMax, 0)));
    end
    step(2);
    setStart(which, 1'b0);
    step(8);
    if (which == 1) begin
      checkOutput({tag, "_word_count"}, 32'(wc_b), 32'(nwc));
      checkOutput({tag, "_program_off"}, 32'(off_b), 32'd1);
      checkOutput({tag, "_overflow"}, 32'(ovf_b), 32'(nw >= cap));
      checkOutput({tag, "_stall_busy"}, {30'd0, stall_b, busy_b}, 32'd0);
      checkOutput({tag, "_write_pulses"}, 32'(wr_cnt_b - w0), 32'(nwc));
      checkOutput({tag, "_pending"}, 32'(exp_b.size()), 32'd0);
    end else begin
      checkOutput({tag, "_word_count"}, 32'(wc_a), 32'(nwc));
      checkOutput({tag, "_program_off"}, 32'(off_a), 32'd1);
      checkOutput({tag, "_overflow"}, 32'(ovf_a), 32'(nw >= cap));
      checkOutput({tag, "_stall_busy"}, {30'd0, stall_a, busy_a}, 32'd0);
      checkOutput({tag, "_write_pulses"}, 32'(wr_cnt_a - w0), 32'(nwc));
      checkOutput({tag, "_pending"}, 32'(exp_a.size()), 32'd0);
    end
  endtask

  // Main sequence.
  initial begin
    exp_t e;
    int   w0;
    bit   seen;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #1 rst = 1'b0;
    #3;
    checkOutput("rst_a_flags", {26'd0, stall_a, busy_a, off_a, ovf_a, uwe_a, en_a & we_a & 1'b0}, 32'd0);
    checkOutput("rst_a_word_count", 32'(wc_a), 32'd0);
    checkOutput("rst_b_flags", {27'd0, stall_b, busy_b, off_b, ovf_b, uwe_b}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step(2);
    repeat (3) checkPassthrough();

    stim.delete();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    applyStimulus(0, 2, -1, "seq8");

    stim.delete();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    applyStimulus(0, 3, -1, "pad5");
    checkPassthrough();

    fillRandom(8);
    applyStimulus(0, 0, -1, "b2b");

    stim.delete();
    applyStimulus(0, 2, -1, "empty");

    for (int r = 0; r < 4; r++) begin
      fillRandom(int'($urandom_range(13, 1)));
      applyStimulus(0, 3, -1, "rand_a");
    end

    fillRandom(2);
    e.addr = 0; e.data = {16'h0, stim[1], stim[0]};
    setStart(1, 1'b1);
    step(2);
    sendByte(stim[0]);
    step(1);
    sendByte(stim[1]);
    e.cyc = last_cyc + 16;
    exp_b.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (uwe_b) seen = 1'b1;
    end
    start_b = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("[TB] FAIL idle_timeout: got no write within 40 cycles, required padded write 16 cycles after last byte");
    end
    step(6);
    checkOutput("idle_word_count", 32'(wc_b), 32'd1);
    checkOutput("idle_program_off", 32'(off_b), 32'd1);
    checkOutput("idle_busy", 32'(busy_b), 32'd0);
    checkOutput("idle_pending", 32'(exp_b.size()), 32'd0);

    fillRandom(20);
    applyStimulus(1, 0, 16, "overflow");

    for (int r = 0; r < 2; r++) begin
      fillRandom(int'($urandom_range(11, 1)));
      applyStimulus(1, 3, -1, "rand_b");
    end

    fillRandom(6);
    e.addr = 0; e.data = {stim[3], stim[2], stim[1], stim[0]}; e.cyc = -1;
    exp_a.push_back(e);
    setStart(0, 1'b1);
    step(2);
    foreach (stim[i]) sendByte(stim[i]);
    step(3);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid_stall_busy", {30'd0, stall_a, busy_a}, 32'd0);
    checkOutput("rst_mid_uwe", 32'(uwe_a), 32'd0);
    checkOutput("rst_mid_word_count", 32'(wc_a), 32'd0);
    checkOutput("rst_mid_flags", {30'd0, off_a, ovf_a}, 32'd0);
    start_a = 1'b0;
    w0 = wr_cnt_a;
    @(negedge clk) rst = 1'b1;
    step(10);
    checkOutput("rst_mid_no_write", 32'(wr_cnt_a - w0), 32'd0);
    checkOutput("rst_mid_pending", 32'(exp_a.size()), 32'd0);
    checkPassthrough();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
